gemm_tile_engine: RTL and testbench
===================================

Name: gemm_tile_engine

Overview:
- Parametrised successor of the N×N matrix-multiply stage. Computes C = A×B on one N×N tile per transaction.
- Adds a valid/ready input handshake, a runtime signed/unsigned mode, and K-dimension accumulation across consecutive tiles held in an internal partial-sum buffer.
- Adds a backpressured row-stream output.
- Sits between the img2col/S2P buffer stage and the result writer.

Parameters:
- N, 4, tile dimension (rows, columns and inner length).
- DATA_WIDTH, 8, operand element width.
- ACC_WIDTH, 2*DATA_WIDTH+$clog2(N), accumulator and result element width.

Ports:
- clk  in  1  clock; all logic rising-edge.
- rstn  in  1  asynchronous active-low reset.
- in_valid  in  1  tile offered.
- in_ready  out  1  engine can accept a tile.
- in_a  in  N*N*DATA_WIDTH  tile A, row-major; element (r,c) at bits [(N*N-1-(r*N+c))*DATA_WIDTH +: DATA_WIDTH], i.e. (0,0) in the MSBs.
- in_b  in  N*N*DATA_WIDTH  tile B, same packing as in_a.
- in_first  in  1  1 = start a new accumulation (discard partial sums).
- in_last  in  1  1 = final K-tile; emit results after this tile.
- in_signed  in  1  1 = two's-complement operands, 0 = unsigned.
- out_valid  out  1  result row available.
- out_ready  in  1  consumer accepts the row.
- out_row  out  N*ACC_WIDTH  C[r][k] at bits [(N-1-k)*ACC_WIDTH +: ACC_WIDTH].
- out_last  out  1  high with row N-1.
- busy  out  1  state != IDLE.

Behaviour:
- Reset (async, rstn=0):
  - State = IDLE; all counters, capture registers and out_row clear to 0.
  - Every partial-sum row clears to 0.
  - Outputs: in_ready=1, out_valid=0, out_last=0, busy=0.
- State IDLE:
  - in_ready=1.
  - On in_valid&&in_ready: capture A, B, first, last and signed.
  - Set row=0, j=0; go to COMPUTE.
- State COMPUTE:
  - Runs exactly N*N cycles; in_ready=0.
  - Each cycle, lane k (k=0..N-1) does lane_acc[k] += ext(A[row][j]) * ext(B[j][k]).
  - ext() sign-extends when signed=1, otherwise zero-extends, to ACC_WIDTH. Arithmetic wraps modulo 2^ACC_WIDTH; there is no saturation.
  - On the j=N-1 cycle, psum[row][k] <= (first ? 0 : psum[row][k]) + lane total including this cycle's product. lane_acc then clears, j=0 and row increments.
  - After row N-1 completes:
    - last=1: go to OUT.
    - last=0: go to IDLE.
- Latency:
  - last=1: out_valid rises N*N edges after the accepting edge.
  - last=0: in_ready returns N*N edges after the accepting edge.
- State OUT:
  - out_valid=1 and out_row=psum[orow].
  - out_last=(orow==N-1).
  - Each out_valid&&out_ready advances orow.
  - Handshake on row N-1: go to IDLE; in_ready=1 next cycle.
- Backpressure: while out_ready=0, out_row and out_last stay stable and out_valid stays 1.
- Inputs ignored when not ready: in_valid while in_ready=0 is ignored, and the tile is not captured.
- first=0 with no prior tile: accumulates onto the reset value 0, which is legal.
- first=1 and last=1 together: plain single-tile GEMM.
- Reset mid-operation: everything aborts immediately, including psum. No partial row is ever emitted.

Decomposition:
- Shared config include: N, DATA_WIDTH, ACC_WIDTH default macros, and the state encoding constants (IDLE/COMPUTE/OUT).
- One sub-module, gemm_mac_lane:
  - Holds one lane's extend, multiply and accumulate, plus the row-total output.
  - Ports: clk, rstn, clr, en, is_signed, a, b, acc.
- The top instantiates N lanes and owns the FSM, counters, capture registers and psum buffer.

Test Plan:
- N=4, DATA_WIDTH=8, ACC_WIDTH=20 throughout.
- Identity: A=I, B=1..16 row-major, first=last=1, signed=0, out_ready=1.
  - out_valid at +16 edges.
  - Rows {1,2,3,4}, {5,6,7,8}, {9,10,11,12}, {13,14,15,16}.
  - out_last only on row 3.
- Signed mode: A all 0xFF, B all 0x02, first=last=1.
  - signed=1: every element 0xFFFF8 (-8).
  - Same data with signed=0: every element 2040.
- Accumulate: tile1 first=1,last=0; tile2 first=0,last=1; A=B=all ones in both.
  - No out_valid after tile1; in_ready back at +16.
  - After tile2, all 16 elements = 8.
- Backpressure: identity case with out_ready=0 for 5 cycles while row 1 is presented.
  - out_row holds {5,6,7,8} stable; no row skipped or duplicated.
  - in_ready stays 0 until row 3 handshake; in_valid pulses during OUT are not captured.
- Max unsigned: A=B=all 0xFF, signed=0.
  - Every element 260100 (0x3F804); no wrap.
- Reset mid-compute: assert rstn=0 at COMPUTE cycle 7.
  - Immediately out_valid=0, in_ready=1, busy=0.
  - Next tile first=0,last=1 with A=I, B=1..16 outputs exactly B, proving psum was cleared.

Source files
------------

// File: rtl/gemm_tile_engine_pkg.sv
// Shared configuration for the GEMM tile engine: default geometry and FSM state encoding.
package gemm_tile_engine_pkg;

  localparam int GEMM_N          = 4;
  localparam int GEMM_DATA_WIDTH = 8;
  localparam int GEMM_ACC_WIDTH  = 2*GEMM_DATA_WIDTH + $clog2(GEMM_N);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_COMPUTE = 2'd1,
    ST_OUT     = 2'd2
  } gemm_state_e;

endpackage

// File: rtl/gemm_mac_lane.sv
// One output-column MAC lane: extend, multiply, accumulate over the inner dimension.
// acc already includes the current cycle's product so the owner can latch a row total on the last step.
module gemm_mac_lane
  import gemm_tile_engine_pkg::*;
#(
  parameter int DATA_WIDTH = GEMM_DATA_WIDTH,
  parameter int ACC_WIDTH  = GEMM_ACC_WIDTH
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic                  clr,
  input  logic                  en,
  input  logic                  is_signed,
  input  logic [DATA_WIDTH-1:0] a,
  input  logic [DATA_WIDTH-1:0] b,
  output logic [ACC_WIDTH-1:0]  acc
);

  logic [ACC_WIDTH-1:0] a_ext;
  logic [ACC_WIDTH-1:0] b_ext;
  logic [ACC_WIDTH-1:0] prod;
  logic [ACC_WIDTH-1:0] acc_q;

  // Products are only needed modulo 2^ACC_WIDTH, so multiplying the extended operands suffices.
  always_comb begin
    a_ext = is_signed ? {{(ACC_WIDTH-DATA_WIDTH){a[DATA_WIDTH-1]}}, a}
                      : {{(ACC_WIDTH-DATA_WIDTH){1'b0}}, a};
    b_ext = is_signed ? {{(ACC_WIDTH-DATA_WIDTH){b[DATA_WIDTH-1]}}, b}
                      : {{(ACC_WIDTH-DATA_WIDTH){1'b0}}, b};
    prod  = a_ext * b_ext;
    acc   = acc_q + (en ? prod : '0);
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn)     acc_q <= '0;
    else if (clr)  acc_q <= '0;
    else if (en)   acc_q <= acc;
  end

endmodule

// File: rtl/gemm_tile_engine.sv
// N x N tile GEMM with K-tile accumulation in a partial-sum buffer and a backpressured row output.
// One row of C is built per N cycles using N parallel lanes, one per output column.
module gemm_tile_engine
  import gemm_tile_engine_pkg::*;
#(
  parameter int N          = GEMM_N,
  parameter int DATA_WIDTH = GEMM_DATA_WIDTH,
  parameter int ACC_WIDTH  = 2*DATA_WIDTH + $clog2(N)
) (
  input  logic                       clk,
  input  logic                       rstn,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [N*N*DATA_WIDTH-1:0]  in_a,
  input  logic [N*N*DATA_WIDTH-1:0]  in_b,
  input  logic                       in_first,
  input  logic                       in_last,
  input  logic                       in_signed,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [N*ACC_WIDTH-1:0]     out_row,
  output logic                       out_last,
  output logic                       busy
);

  localparam int            CW       = (N > 1) ? $clog2(N) : 1;
  localparam logic [CW-1:0] IDX_LAST = CW'(N-1);

  gemm_state_e state_q, state_d;

  logic [CW-1:0]               row_q, j_q, orow_q;
  logic [N*N*DATA_WIDTH-1:0]   a_q, b_q;
  logic                        first_q, last_q, signed_q;
  logic [ACC_WIDTH-1:0]        psum_q [N][N];
  logic [DATA_WIDTH-1:0]       a_el [N][N];
  logic [DATA_WIDTH-1:0]       b_el [N][N];
  logic [ACC_WIDTH-1:0]        lane_acc [N];
  logic                        accept, row_done, mac_en, out_fire;

  always_comb begin
    for (int r = 0; r < N; r++) begin
      for (int c = 0; c < N; c++) begin
        a_el[r][c] = a_q[(N*N-1-(r*N+c))*DATA_WIDTH +: DATA_WIDTH];
        b_el[r][c] = b_q[(N*N-1-(r*N+c))*DATA_WIDTH +: DATA_WIDTH];
      end
    end
  end

  always_comb begin
    state_d   = state_q;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    case (state_q)
      ST_IDLE: begin
        in_ready = 1'b1;
        if (in_valid) state_d = ST_COMPUTE;
      end
      ST_COMPUTE: begin
        if (j_q == IDX_LAST && row_q == IDX_LAST) state_d = last_q ? ST_OUT : ST_IDLE;
      end
      ST_OUT: begin
        out_valid = 1'b1;
        if (out_ready && orow_q == IDX_LAST) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    accept   = in_valid && in_ready;
    mac_en   = (state_q == ST_COMPUTE);
    row_done = mac_en && (j_q == IDX_LAST);
    out_fire = out_valid && out_ready;
    busy     = (state_q != ST_IDLE);
    out_last = (state_q == ST_OUT) && (orow_q == IDX_LAST);
    for (int k = 0; k < N; k++) begin
      out_row[(N-1-k)*ACC_WIDTH +: ACC_WIDTH] = (state_q == ST_OUT) ? psum_q[orow_q][k] : '0;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) state_q <= ST_IDLE;
    else       state_q <= state_d;
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      row_q    <= '0;
      j_q      <= '0;
      orow_q   <= '0;
      a_q      <= '0;
      b_q      <= '0;
      first_q  <= 1'b0;
      last_q   <= 1'b0;
      signed_q <= 1'b0;
    end else if (accept) begin
      row_q    <= '0;
      j_q      <= '0;
      orow_q   <= '0;
      a_q      <= in_a;
      b_q      <= in_b;
      first_q  <= in_first;
      last_q   <= in_last;
      signed_q <= in_signed;
    end else begin
      if (row_done) begin
        j_q   <= '0;
        row_q <= row_q + CW'(1);
      end else if (mac_en) begin
        j_q <= j_q + CW'(1);
      end
      if (out_fire) orow_q <= orow_q + CW'(1);
    end
  end

  // first=1 discards whatever the previous accumulation left in this row.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      for (int r = 0; r < N; r++)
        for (int k = 0; k < N; k++)
          psum_q[r][k] <= '0;
    end else if (row_done) begin
      for (int k = 0; k < N; k++)
        psum_q[row_q][k] <= lane_acc[k] + (first_q ? '0 : psum_q[row_q][k]);
    end
  end

  for (genvar k = 0; k < N; k++) begin : g_lane
    gemm_mac_lane #(
      .DATA_WIDTH (DATA_WIDTH),
      .ACC_WIDTH  (ACC_WIDTH)
    ) u_lane (
      .clk       (clk),
      .rstn      (rstn),
      .clr       (row_done),
      .en        (mac_en),
      .is_signed (signed_q),
      .a         (a_el[row_q][j_q]),
      .b         (b_el[j_q][k]),
      .acc       (lane_acc[k])
    );
  end

endmodule

// File: tb/tb_gemm_tile_engine.sv
// Directed bench for gemm_tile_engine at N=4, DATA_WIDTH=8, ACC_WIDTH=20.
module tb_gemm_tile_engine;

  localparam int N  = 4;
  localparam int DW = 8;
  localparam int AW = 20;

  logic              clk = 1'b0;
  logic              rstn = 1'b0;
  logic              in_valid = 1'b0;
  logic              in_ready;
  logic [N*N*DW-1:0] in_a = '0;
  logic [N*N*DW-1:0] in_b = '0;
  logic              in_first = 1'b0;
  logic              in_last = 1'b0;
  logic              in_signed = 1'b0;
  logic              out_valid;
  logic              out_ready = 1'b1;
  logic [N*AW-1:0]   out_row;
  logic              out_last;
  logic              busy;

  int n_checks = 0;
  int n_fail   = 0;
  logic [N*AW-1:0] exp_rows [4];

  gemm_tile_engine #(.N(N), .DATA_WIDTH(DW), .ACC_WIDTH(AW)) dut (
    .clk       (clk),
    .rstn      (rstn),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_a      (in_a),
    .in_b      (in_b),
    .in_first  (in_first),
    .in_last   (in_last),
    .in_signed (in_signed),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_row   (out_row),
    .out_last  (out_last),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [N*N*DW-1:0] tile_fill(input logic [7:0] v);
    logic [N*N*DW-1:0] t;
    for (int i = 0; i < N*N; i++) t[(N*N-1-i)*DW +: DW] = v;
    return t;
  endfunction

  function automatic logic [N*N*DW-1:0] tile_ident();
    logic [N*N*DW-1:0] t;
    for (int i = 0; i < N*N; i++) t[(N*N-1-i)*DW +: DW] = (i/N == i%N) ? 8'd1 : 8'd0;
    return t;
  endfunction

  function automatic logic [N*N*DW-1:0] tile_seq();
    logic [N*N*DW-1:0] t;
    for (int i = 0; i < N*N; i++) t[(N*N-1-i)*DW +: DW] = 8'(i+1);
    return t;
  endfunction

  function automatic logic [N*AW-1:0] row4(input int e0, input int e1, input int e2, input int e3);
    return {e0[AW-1:0], e1[AW-1:0], e2[AW-1:0], e3[AW-1:0]};
  endfunction

  task automatic set_rows_all(input int v);
    for (int r = 0; r < 4; r++) exp_rows[r] = row4(v, v, v, v);
  endtask

  task automatic set_rows_seq();
    for (int r = 0; r < 4; r++) exp_rows[r] = row4(4*r+1, 4*r+2, 4*r+3, 4*r+4);
  endtask

  // Called at posedge+1; leaves the bench at accept-edge+1.
  task automatic send(input logic [N*N*DW-1:0] a, input logic [N*N*DW-1:0] b,
                      input logic f, input logic l, input logic s);
    int t = 0;
    while (!in_ready && t < 200) begin
      @(posedge clk); #1; t++;
    end
    check("accept_ready", in_ready, 1'b1);
    in_a = a; in_b = b; in_first = f; in_last = l; in_signed = s; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic latency(input bit want_out, input string tag);
    int  cnt  = 0;
    bit  seen = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk); #1; cnt++;
      if (out_valid) seen = 1'b1;
      if (want_out && out_valid) break;
      if (!want_out && in_ready) break;
    end
    check(tag, cnt, 16);
    if (!want_out) check({tag, "_no_out"}, seen, 1'b0);
  endtask

  task automatic collect_rows(input int from, input string tag);
    for (int r = from; r < 4; r++) begin
      int t = 0;
      while (!out_valid && t < 40) begin
        @(posedge clk); #1; t++;
      end
      check($sformatf("%s_row%0d", tag, r), out_row, exp_rows[r]);
      check($sformatf("%s_last%0d", tag, r), out_last, (r == 3));
      @(posedge clk); #1;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1);
  end

  initial begin
    #12;
    check("rst_in_ready", in_ready, 1'b1);
    check("rst_out_valid", out_valid, 1'b0);
    check("rst_out_last", out_last, 1'b0);
    check("rst_busy", busy, 1'b0);
    check("rst_out_row", out_row, '0);
    rstn = 1'b1;
    @(posedge clk); #1;

    // identity x 1..16
    send(tile_ident(), tile_seq(), 1'b1, 1'b1, 1'b0);
    latency(1'b1, "ident_lat");
    set_rows_seq();
    collect_rows(0, "ident");
    check("ident_idle", busy, 1'b0);

    // signed / unsigned with the same bit patterns
    send(tile_fill(8'hFF), tile_fill(8'h02), 1'b1, 1'b1, 1'b1);
    latency(1'b1, "sgn_lat");
    set_rows_all(-8);
    collect_rows(0, "sgn");
    send(tile_fill(8'hFF), tile_fill(8'h02), 1'b1, 1'b1, 1'b0);
    latency(1'b1, "uns_lat");
    set_rows_all(2040);
    collect_rows(0, "uns");

    // K accumulation across two tiles
    send(tile_fill(8'h01), tile_fill(8'h01), 1'b1, 1'b0, 1'b0);
    latency(1'b0, "acc1_lat");
    send(tile_fill(8'h01), tile_fill(8'h01), 1'b0, 1'b1, 1'b0);
    latency(1'b1, "acc2_lat");
    set_rows_all(8);
    collect_rows(0, "acc");

    // backpressure on row 1, with an ignored tile offer during OUT
    send(tile_ident(), tile_seq(), 1'b1, 1'b1, 1'b0);
    latency(1'b1, "bp_lat");
    set_rows_seq();
    check("bp_row0", out_row, exp_rows[0]);
    @(posedge clk); #1;
    out_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      check($sformatf("bp_hold_row%0d", i), out_row, exp_rows[1]);
      check($sformatf("bp_hold_valid%0d", i), out_valid, 1'b1);
      check($sformatf("bp_hold_rdy%0d", i), in_ready, 1'b0);
      check($sformatf("bp_hold_last%0d", i), out_last, 1'b0);
      if (i == 2) begin
        in_a = tile_fill(8'h55); in_b = tile_fill(8'h55);
        in_first = 1'b1; in_last = 1'b1; in_valid = 1'b1;
      end else begin
        in_valid = 1'b0;
      end
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    collect_rows(1, "bp");
    check("bp_ready_after", in_ready, 1'b1);
    check("bp_busy_after", busy, 1'b0);
    @(posedge clk); #1;
    check("bp_not_captured", busy, 1'b0);

    // max unsigned, no wrap
    send(tile_fill(8'hFF), tile_fill(8'hFF), 1'b1, 1'b1, 1'b0);
    latency(1'b1, "max_lat");
    set_rows_all(260100);
    collect_rows(0, "max");

    // reset during COMPUTE cycle 7, then first=0 must see a cleared psum
    send(tile_fill(8'h03), tile_fill(8'h03), 1'b1, 1'b1, 1'b0);
    repeat (6) @(posedge clk);
    #1 rstn = 1'b0;
    #1;
    check("mid_rst_out_valid", out_valid, 1'b0);
    check("mid_rst_in_ready", in_ready, 1'b1);
    check("mid_rst_busy", busy, 1'b0);
    #2 rstn = 1'b1;
    @(posedge clk); #1;
    send(tile_ident(), tile_seq(), 1'b0, 1'b1, 1'b0);
    latency(1'b1, "post_rst_lat");
    set_rows_seq();
    collect_rows(0, "post_rst");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
